led_pattern_sequencer: RTL
==========================

# led_pattern_sequencer

Switch-controlled LED pattern sequencer for the board's 8 slide switches and 8 LEDs. It extends the board's fixed-rate blinker into a scheduler: a base tick divider sets the time base, and a programmable step divider decides when the pattern engine advances. The engine is selected from the switches and is one of blink, rotate, ping-pong or binary count. The block sits directly between the switch pins and the LED pins in the top level.

## Interface
- `BASE_DIV`, default 49999999: base tick terminal count; the base tick period is BASE_DIV+1 clk cycles (1 s at 50 MHz).
- `DEBOUNCE_CYCLES`, default 1000000: stable-cycle count required per switch. Used only with `LED_SEQ_DEBOUNCE_EN`.
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sw`, input, 8: raw asynchronous switches.
  - sw[7] enable
  - sw[6] direction
  - sw[5] pause
  - sw[4:2] speed
  - sw[1:0] mode: 00 blink, 01 rotate, 10 ping-pong, 11 count
- `led`, output, 8: pattern register, driven directly from a flop.
- `step_pulse`, output, 1: registered one-cycle pulse on each pattern advance.

## Operation
- **Switch input:** sw passes through a 2-flop synchronizer (optionally followed by the debouncer). This gives en_s, dir_s, pause_s, speed_s and mode_s.
- **Base divider:** base_cnt counts 0..BASE_DIV and then wraps to 0. base_tick is asserted while base_cnt==BASE_DIV.
- **Step divider:** step_cnt counts base ticks.
  - A step fires on a base_tick when step_cnt>=speed_s; step_cnt then clears.
  - Step interval = (speed_s+1)*(BASE_DIV+1) cycles.
  - Lowering the speed mid-interval steps on the next base_tick.
- **Reload event:** en_s rising, or mode_s differing from the registered mode_q.
  - Loads the initial pattern, clears base_cnt and step_cnt, and sets the ping-pong state to GO_LEFT.
  - Reload has priority over a same-cycle step; step_pulse is not asserted.
- **Initial patterns:** blink 0x00, rotate 0x01, ping-pong 0x01, count 0x00.
- **Step action per mode:**
  - Blink: led <= ~led.
  - Rotate: dir_s=0 rotates left ({led[6:0],led[7]}); dir_s=1 rotates right.
  - Ping-pong: dir_s is ignored. FSM with two states:
    - GO_LEFT: if led==0x80, led<=0x40 and the state becomes GO_RIGHT; otherwise led<=led<<1.
    - GO_RIGHT: if led==0x01, led<=0x02 and the state becomes GO_LEFT; otherwise led<=led>>1.
  - Count: dir_s=0 gives led+1 mod 256; dir_s=1 gives led-1 mod 256. Wraps 0xFF→0x00 and 0x00→0xFF.
- **Disabled (en_s=0):** led forced to 0x00, counters held at 0, step_pulse 0.
- **Pause (pause_s=1, enabled):** base_cnt, step_cnt and led hold; no steps. On release, counting resumes from the held counts, so the remaining interval is preserved.
- **Live switch changes:** a dir_s change takes effect at the next step with no reload. A speed_s change takes effect immediately via the >= compare.

## Timing
- **Reset values:** led=0x00, step_pulse=0, base_cnt=0, step_cnt=0, mode_q=00, FSM=GO_LEFT, synchronizer/debounce flops 0. All apply asynchronously on rst assertion.
- **Reset release:** the first edge after release behaves as a normal cycle.
- **Reset mid-operation:** all outputs return to the reset values immediately; no residual step_pulse.
- **Switch-to-effect latency (no debounce):** 2 edges through the synchronizer, then the reload or force-off is visible on led at the 3rd edge.
- **Step timing:** step_pulse and the new led value appear on the same edge, one edge after the base_tick cycle that triggers the step.
- **First step after reload:** occurs (speed_s+1)*(BASE_DIV+1) cycles after the reload edge.

## Configuration
- **Macro `LED_SEQ_DEBOUNCE_EN` defined:**
  - Each synchronized bit updates its filtered value only after DEBOUNCE_CYCLES consecutive identical samples.
  - Per-bit counters reset to 0 on any mismatch.
  - Latency = 2 + DEBOUNCE_CYCLES edges.
- **Macro undefined:**
  - Synchronizer output is used directly; the DEBOUNCE_CYCLES parameter is unused.
  - Intended for simulation and for boards with hardware debounce.

## Test plan
Bench settings: BASE_DIV=3, macro undefined.

1. **Reset and rotate:** assert rst mid-run, then release and apply sw=0x81. led=0x00 during reset, 0x01 three edges after the sw change, then 0x02, 0x04 … 0x80, 0x01 every 4 cycles, with step_pulse aligned to each change.
2. **Ping-pong:** sw=0x82. led sequence 01,02,04,…,80,40,20,…,01,02, with 4 cycles per step and no repeated endpoint.
3. **Count down at speed 3:** sw=0xCF. led 0x00→0xFF→0xFE, one step every 16 cycles.
4. **Pause:** blink (sw=0x80); set sw[5] two cycles into an interval. led and step_pulse frozen for 50 cycles; after clearing sw[5], the next toggle follows after the remaining interval plus the synchronizer delay.
5. **Reload vs step:** change mode so the reload lands in the same cycle as a step. led takes the new initial value, step_pulse stays 0, and the next step occurs a full interval later.
6. **Disable and re-enable:** clear sw[7]. led=0x00 three edges later; re-setting sw[7] loads the initial pattern for the current mode.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: switch-controlled LED pattern scheduler.
// A base tick divider sets the time base. A step divider, programmed from the
// speed switches, decides when the selected pattern engine advances. The
// engines are blink, rotate, ping-pong and binary count.
// Optional feature macro: LED_SEQ_DEBOUNCE_EN adds a per-switch debounce
// filter after the 2-flop synchronizer.
module led_pattern_sequencer #(
  parameter int BASE_DIV        = 49999999,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic       step_pulse
);

  localparam int BW = (BASE_DIV > 0) ? $clog2(BASE_DIV + 1) : 1;
  localparam logic [BW-1:0] BASE_MAX = BW'(BASE_DIV);

  typedef enum logic {
    GO_LEFT  = 1'b0,
    GO_RIGHT = 1'b1
  } pp_state_t;

  logic [7:0]    sw_meta_q, sw_sync_q;
  logic [7:0]    sw_f;
  logic          en_s, dir_s, pause_s;
  logic [2:0]    speed_s;
  logic [1:0]    mode_s;

  logic [BW-1:0] base_cnt_q, base_cnt_d;
  logic [2:0]    step_cnt_q, step_cnt_d;
  logic [7:0]    led_q, led_d;
  logic          step_pulse_q, step_pulse_d;
  logic [1:0]    mode_q, mode_d;
  logic          en_prev_q, en_prev_d;
  pp_state_t     pp_state_q, pp_state_d;

  logic          base_tick;
  logic          reload;

  // Initial LED value loaded for each mode on a reload event
  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    case (m)
      2'b01:   init_pattern = 8'h01;
      2'b10:   init_pattern = 8'h01;
      default: init_pattern = 8'h00;
    endcase
  endfunction

  // Two-flop synchronizer bringing the raw switches into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [7:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [7:0]         sw_filt_q, sw_filt_d;

  // Per-bit filter: accept a new level only after it has been stable long enough
  always_comb begin
    db_cnt_d  = db_cnt_q;
    sw_filt_d = sw_filt_q;
    for (int i = 0; i < 8; i++) begin
      if (sw_sync_q[i] == sw_filt_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]  = '0;
        sw_filt_d[i] = sw_sync_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  // Debounce counter and filtered-value registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      sw_filt_q <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      sw_filt_q <= sw_filt_d;
    end
  end

  assign sw_f = sw_filt_q;
`else
  assign sw_f = sw_sync_q;
`endif

  assign en_s    = sw_f[7];
  assign dir_s   = sw_f[6];
  assign pause_s = sw_f[5];
  assign speed_s = sw_f[4:2];
  assign mode_s  = sw_f[1:0];

  assign base_tick = (base_cnt_q == BASE_MAX);
  assign reload    = (en_s && !en_prev_q) || (mode_s != mode_q);

  // Scheduler and pattern engine: disable beats reload, reload beats step,
  // and pause freezes the counters so the remaining interval survives
  always_comb begin
    base_cnt_d   = base_cnt_q;
    step_cnt_d   = step_cnt_q;
    led_d        = led_q;
    step_pulse_d = 1'b0;
    pp_state_d   = pp_state_q;
    mode_d       = mode_s;
    en_prev_d    = en_s;

    if (!en_s) begin
      base_cnt_d = '0;
      step_cnt_d = '0;
      led_d      = 8'h00;
      pp_state_d = GO_LEFT;
    end else if (reload) begin
      base_cnt_d = '0;
      step_cnt_d = '0;
      led_d      = init_pattern(mode_s);
      pp_state_d = GO_LEFT;
    end else if (!pause_s) begin
      base_cnt_d = base_tick ? '0 : base_cnt_q + BW'(1);
      if (base_tick) begin
        if (step_cnt_q >= speed_s) begin
          step_cnt_d   = '0;
          step_pulse_d = 1'b1;
          case (mode_s)
            2'b00: led_d = ~led_q;
            2'b01: led_d = dir_s ? {led_q[0], led_q[7:1]} : {led_q[6:0], led_q[7]};
            2'b10: begin
              if (pp_state_q == GO_LEFT) begin
                if (led_q == 8'h80) begin
                  led_d      = 8'h40;
                  pp_state_d = GO_RIGHT;
                end else begin
                  led_d = led_q << 1;
                end
              end else begin
                if (led_q == 8'h01) begin
                  led_d      = 8'h02;
                  pp_state_d = GO_LEFT;
                end else begin
                  led_d = led_q >> 1;
                end
              end
            end
            default: led_d = dir_s ? led_q - 8'h01 : led_q + 8'h01;
          endcase
        end else begin
          step_cnt_d = step_cnt_q + 3'd1;
        end
      end
    end
  end

  // State register for counters, pattern, ping-pong FSM and edge detectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_cnt_q   <= '0;
      step_cnt_q   <= '0;
      led_q        <= 8'h00;
      step_pulse_q <= 1'b0;
      mode_q       <= 2'b00;
      en_prev_q    <= 1'b0;
      pp_state_q   <= GO_LEFT;
    end else begin
      base_cnt_q   <= base_cnt_d;
      step_cnt_q   <= step_cnt_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
      mode_q       <= mode_d;
      en_prev_q    <= en_prev_d;
      pp_state_q   <= pp_state_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_pulse_q;

endmodule
